fft_seq_ctrl: RTL and testbench

FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

---
 rtl/fft_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fft_seq_ctrl
//   Frame sequencer for an in-place radix-2 FFT core. A frame walks through
//   LOAD (accept NUMSAMPLES input beats), COMPUTE (NUMSTAGES stages of
//   2^(NUMSTAGES-2) butterfly cycles each), UNLOAD (emit NUMSAMPLES beats)
//   and DONE (one-cycle completion pulse), then returns to IDLE.
//
// Ports
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset, forces IDLE and zero outputs
//   start        : frame request, honoured only in IDLE
//   in_valid     : upstream sample present (LOAD handshake)
//   in_ready     : sequencer accepts a sample (high throughout LOAD)
//   out_ready    : downstream accepts a sample (UNLOAD handshake)
//   out_valid    : output sample present (high throughout UNLOAD)
//   sample_idx   : index of the sample being loaded / unloaded
//   ld_data      : stage mux select, high during LOAD
//   counter_r    : butterfly cycle counter within the current stage
//   stage_num_r  : current FFT stage
//   busy         : high in every state except IDLE
//   done         : one-cycle pulse when the frame has been fully unloaded
// -----------------------------------------------------------------------------
module fft_seq_ctrl #(
  parameter int NUMSTAGES  = 5,
  parameter int NUMSAMPLES = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [NUMSTAGES-1:0] sample_idx,
  output logic                 ld_data,
  output logic [NUMSTAGES-3:0] counter_r,
  output logic [2:0]           stage_num_r,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = NUMSTAGES - 2;

  localparam logic [NUMSTAGES-1:0] LAST_IDX   = NUMSTAGES'(NUMSAMPLES - 1);
  localparam logic [NUMSTAGES-1:0] IDX_ONE    = NUMSTAGES'(1);
  localparam logic [CW-1:0]        CNT_ONE    = CW'(1);
  localparam logic [2:0]           LAST_STAGE = 3'(NUMSTAGES - 1);
  localparam logic [2:0]           STAGE_ONE  = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t                 state_reg,      state_next;
  logic [NUMSTAGES-1:0]   sample_idx_reg, sample_idx_next;
  logic [CW-1:0]          counter_reg,    counter_next;
  logic [2:0]             stage_reg,      stage_next;

  logic in_beat;
  logic out_beat;
  logic stage_end;

  assign in_beat   = (state_reg == ST_LOAD)    && in_valid;
  assign out_beat  = (state_reg == ST_UNLOAD)  && out_ready;
  assign stage_end = (state_reg == ST_COMPUTE) && (&counter_reg);

  // State and datapath registers. The reset value of every register decodes
  // to all-zero outputs, so reset clears the outputs without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      sample_idx_reg <= '0;
      counter_reg    <= '0;
      stage_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      sample_idx_reg <= sample_idx_next;
      counter_reg    <= counter_next;
      stage_reg      <= stage_next;
    end
  end

  // Next-state and next-counter logic.
  always_comb begin
    state_next      = state_reg;
    sample_idx_next = '0;
    counter_next    = '0;
    stage_next      = '0;

    unique case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_LOAD;
      end

      ST_LOAD: begin
        sample_idx_next = sample_idx_reg;
        if (in_beat) begin
          if (sample_idx_reg == LAST_IDX) begin
            sample_idx_next = '0;
            state_next      = ST_COMPUTE;
          end else begin
            sample_idx_next = sample_idx_reg + IDX_ONE;
          end
        end
      end

      ST_COMPUTE: begin
        // The counter wraps naturally from all-ones to zero; the stage
        // advances on that same cycle. Leaving after the last stage clears
        // the stage number so it reads 0 outside COMPUTE.
        counter_next = counter_reg + CNT_ONE;
        stage_next   = stage_reg;
        if (stage_end) begin
          if (stage_reg == LAST_STAGE) begin
            stage_next = '0;
            state_next = ST_UNLOAD;
          end else begin
            stage_next = stage_reg + STAGE_ONE;
          end
        end
      end

      ST_UNLOAD: begin
        sample_idx_next = sample_idx_reg;
        if (out_beat) begin
          if (sample_idx_reg == LAST_IDX) begin
            sample_idx_next = '0;
            state_next      = ST_DONE;
          end else begin
            sample_idx_next = sample_idx_reg + IDX_ONE;
          end
        end
      end

      ST_DONE: begin
        // start is deliberately not sampled here; a new frame must be
        // requested from IDLE.
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    in_ready    = 1'b0;
    ld_data     = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    busy        = (state_reg != ST_IDLE);
    sample_idx  = sample_idx_reg;
    counter_r   = counter_reg;
    stage_num_r = stage_reg;

    unique case (state_reg)
      ST_LOAD: begin
        in_ready = 1'b1;
        ld_data  = 1'b1;
      end
      ST_UNLOAD: out_valid = 1'b1;
      ST_DONE:   done      = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_seq_ctrl
//   Drives frames through fft_seq_ctrl and compares every cycle against a
//   frame-level model: during LOAD/UNLOAD sample_idx equals the number of
//   beats accepted so far, during COMPUTE cycle k shows counter k mod 8 and
//   stage k / 8, and each phase has fixed flag values.
// -----------------------------------------------------------------------------
module tb_fft_seq_ctrl;

  localparam int NS  = 5;
  localparam int N   = 32;
  localparam int CPS = 1 << (NS - 2);
  localparam int NCOMP = NS * CPS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic       out_ready;
  logic       out_valid;
  logic [4:0] sample_idx;
  logic       ld_data;
  logic [2:0] counter_r;
  logic [2:0] stage_num_r;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fft_seq_ctrl #(.NUMSTAGES(NS), .NUMSAMPLES(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .sample_idx  (sample_idx),
    .ld_data     (ld_data),
    .counter_r   (counter_r),
    .stage_num_r (stage_num_r),
    .busy        (busy),
    .done        (done)
  );

  // Observed output bundle: {in_ready,out_valid,sample_idx,ld_data,counter,stage,busy,done}
  logic [15:0] obs;
  assign obs = {in_ready, out_valid, sample_idx, ld_data, counter_r, stage_num_r, busy, done};

  function automatic logic [15:0] ev(bit ir, bit ov, int idx, bit ld, int cnt, int stg,
                                     bit bsy, bit dn);
    return {ir, ov, 5'(idx), ld, 3'(cnt), 3'(stg), bsy, dn};
  endfunction

  // One frame from IDLE back to IDLE. Optional directed stalls at a given
  // index, random stalls by percentage, optional reset at COMPUTE cycle abort_k.
  task automatic run_frame(input string tag, input int pin, input int pout,
                           input bit hold_start,
                           input int sin_idx, input int sin_len,
                           input int sout_idx, input int sout_len,
                           input int abort_k,
                           output int load_cyc, output int unload_cyc);
    int acc;
    int stl;
    bit iv;
    bit orr;
    logic [15:0] e;
    load_cyc   = 0;
    unload_cyc = 0;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;

    acc = 0;
    stl = 0;
    while (acc < N) begin
      e = ev(1, 0, acc, 1, 0, 0, 1, 0);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL %s_load beat=%0d actual=%h required=%h", tag, acc, obs, e);
      end
      iv = 1'b1;
      if (acc == sin_idx && stl < sin_len) begin
        iv = 1'b0;
        stl++;
      end else if ($urandom_range(0, 99) >= pin) begin
        iv = 1'b0;
      end
      in_valid  = iv;
      out_ready = 1'($urandom_range(0, 1));
      load_cyc++;
      @(posedge clk); #1;
      if (iv) acc++;
    end

    for (int k = 0; k < NCOMP; k++) begin
      e = ev(0, 0, 0, 0, k % CPS, k / CPS, 1, 0);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL %s_compute k=%0d actual=%h required=%h", tag, k, obs, e);
      end
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 16'h0) begin
          failures++;
          $display("FAIL %s_async_reset actual=%h required=%h", tag, obs, 16'h0);
        end
        return;
      end
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end

    acc = 0;
    stl = 0;
    while (acc < N) begin
      e = ev(0, 1, acc, 0, 0, 0, 1, 0);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL %s_unload beat=%0d actual=%h required=%h", tag, acc, obs, e);
      end
      orr = 1'b1;
      if (acc == sout_idx && stl < sout_len) begin
        orr = 1'b0;
        stl++;
      end else if ($urandom_range(0, 99) >= pout) begin
        orr = 1'b0;
      end
      out_ready = orr;
      in_valid  = 1'($urandom_range(0, 1));
      unload_cyc++;
      @(posedge clk); #1;
      if (orr) acc++;
    end

    e = ev(0, 0, 0, 0, 0, 0, 1, 1);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL %s_done actual=%h required=%h", tag, obs, e);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== 16'h0) begin
      failures++;
      $display("FAIL %s_idle_after actual=%h required=%h", tag, obs, 16'h0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #2;
    checks++;
    if (obs !== 16'h0) begin
      failures++;
      $display("FAIL reset_before_clk actual=%h required=%h", obs, 16'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 16'h0) begin
      failures++;
      $display("FAIL reset_held actual=%h required=%h", obs, 16'h0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== 16'h0) begin
        failures++;
        $display("FAIL idle_no_start cyc=%0d actual=%h required=%h", i, obs, 16'h0);
      end
    end
  endtask

  task automatic test_nominal();
    int lc, uc;
    run_frame("nominal", 100, 100, 1'b0, -1, 0, -1, 0, -1, lc, uc);
    checks++;
    if (lc != N || uc != N) begin
      failures++;
      $display("FAIL nominal_len load=%0d unload=%0d required=%0d", lc, uc, N);
    end
  endtask

  task automatic test_in_stall();
    int lc, uc;
    run_frame("in_stall", 100, 100, 1'b0, 10, 3, -1, 0, -1, lc, uc);
    checks++;
    if (lc != 35) begin
      failures++;
      $display("FAIL in_stall_len actual=%0d required=%0d", lc, 35);
    end
  endtask

  task automatic test_backpressure();
    int lc, uc;
    run_frame("backpressure", 100, 100, 1'b0, -1, 0, 31, 5, -1, lc, uc);
    checks++;
    if (uc != 37) begin
      failures++;
      $display("FAIL backpressure_len actual=%0d required=%0d", uc, 37);
    end
  endtask

  task automatic test_start_held();
    int lc, uc;
    run_frame("held1", 100, 100, 1'b1, -1, 0, -1, 0, -1, lc, uc);
    run_frame("held2", 100, 100, 1'b1, -1, 0, -1, 0, -1, lc, uc);
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== 16'h0) begin
      failures++;
      $display("FAIL held_release_idle actual=%h required=%h", obs, 16'h0);
    end
  endtask

  task automatic test_reset_mid_compute();
    int lc, uc;
    run_frame("rst_mid", 100, 100, 1'b0, -1, 0, -1, 0, 2 * CPS + 5, lc, uc);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== 16'h0) begin
        failures++;
        $display("FAIL rst_mid_idle cyc=%0d actual=%h required=%h", i, obs, 16'h0);
      end
    end
    run_frame("post_rst", 100, 100, 1'b0, -1, 0, -1, 0, -1, lc, uc);
    checks++;
    if (lc != N || uc != N) begin
      failures++;
      $display("FAIL post_rst_len load=%0d unload=%0d required=%0d", lc, uc, N);
    end
  endtask

  task automatic test_random();
    int lc, uc;
    for (int f = 0; f < 4; f++) begin
      run_frame($sformatf("rand%0d", f), $urandom_range(20, 100), $urandom_range(20, 100),
                1'($urandom_range(0, 1)), -1, 0, -1, 0, -1, lc, uc);
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== 16'h0) begin
      failures++;
      $display("FAIL rand_final_idle actual=%h required=%h", obs, 16'h0);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_in_stall();
    test_backpressure();
    test_start_held();
    test_reset_mid_compute();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
